load_down_timer: RTL and testbench

- Loadable, programmable countdown timer. Decrements from a loaded value to zero and flags terminal count.
- Counterpart to the existing enable-gated up counter in the PMIC block. Used for power-sequencing delays and timeouts.
- Supports one-shot mode and auto-reload (periodic) mode, with a sticky done flag cleared by an acknowledge handshake.

---
 rtl/load_down_timer_pkg.sv | 12 +
 rtl/load_down_timer_if.sv | 28 ++
 rtl/load_down_timer.sv | 120 ++++++++++++
 tb/tb_load_down_timer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_down_timer_pkg.sv
// Shared PMIC timer definitions: state encodings and default count width.
package load_down_timer_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/load_down_timer_if.sv
// Control/status bundle of the countdown timer; the master drives strobes, the timer reports status.
interface load_down_timer_if
    import load_down_timer_pkg::*;
#(
    parameter int WIDTH = CNT_W
) ();

    logic [WIDTH-1:0] data;
    logic             load;
    logic             start;
    logic             enable;
    logic             ack;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             tc;

    modport master (
        output data, load, start, enable, ack,
        input  out, busy, done, tc
    );

    modport slave (
        input  data, load, start, enable, ack,
        output out, busy, done, tc
    );

endinterface

// File: rtl/load_down_timer.sv
// Loadable countdown timer with one-shot or auto-reload operation, a sticky done flag
// cleared by ack, and a registered one-cycle terminal-count pulse.
module load_down_timer
    import load_down_timer_pkg::*;
#(
    parameter int WIDTH       = CNT_W,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    load_down_timer_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state, state_n;
    logic [WIDTH-1:0] count, count_n;
    logic [WIDTH-1:0] reload;
    logic             done, done_n;
    logic             tc, tc_n;
    logic             busy;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // busy mirrors the registered state, so it is derived from the next state here.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= ZERO;
            done  <= 1'b0;
            tc    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            count <= count_n;
            done  <= done_n;
            tc    <= tc_n;
            busy  <= (state_n == ST_RUN);
        end
    end

    // NOTE: the reload register is reset as well, so a reload before any load yields a known zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            reload <= ZERO;
        end else if (bus.load) begin
            reload <= bus.data;
        end
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_n = state;
        count_n = count;
        done_n  = done;
        tc_n    = 1'b0;

        if (bus.load) begin
            state_n = ST_IDLE;
            count_n = bus.data;
            done_n  = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (count != ZERO) begin
                            state_n = ST_RUN;
                        end else begin
                            state_n = ST_DONE;
                            tc_n    = 1'b1;
                            done_n  = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // The clear is applied first so a coincident terminal count re-sets done.
                    if (bus.ack) begin
                        done_n = 1'b0;
                    end
                    if (bus.enable) begin
                        if (count > ONE) begin
                            count_n = count - ONE;
                        end else if (count == ONE) begin
                            tc_n   = 1'b1;
                            done_n = 1'b1;
                            if (AUTO_RELOAD && (reload != ZERO)) begin
                                count_n = reload;
                            end else begin
                                count_n = ZERO;
                                state_n = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    count_n = ZERO;
                    if (bus.ack) begin
                        done_n  = 1'b0;
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out  = count;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.tc   = tc;

endmodule

// File: tb/tb_load_down_timer.sv
// Directed bench for load_down_timer: one-shot instance (dut0) and auto-reload instance (dut1).
module tb_load_down_timer;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    load_down_timer_if #(.WIDTH(8)) if0 ();
    load_down_timer_if #(.WIDTH(8)) if1 ();

    load_down_timer #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (if0)
    );

    load_down_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if0.data = '0; if0.load = 1'b0; if0.start = 1'b0; if0.enable = 1'b0; if0.ack = 1'b0;
        if1.data = '0; if1.load = 1'b0; if1.start = 1'b0; if1.enable = 1'b0; if1.ack = 1'b0;
    endtask

    // Vectors are packed as {out, tc, busy, done}.
    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({if0.out, if0.tc, if0.busy, if0.done} !== {8'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_dut0: got %h want %h", {if0.out, if0.tc, if0.busy, if0.done}, {8'd0, 3'b000});
        end
        vectors++;
        if ({if1.out, if1.tc, if1.busy, if1.done} !== {8'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_dut1: got %h want %h", {if1.out, if1.tc, if1.busy, if1.done}, {8'd0, 3'b000});
        end

        if0.data = 8'd10; if0.load = 1'b1;
        tick();
        if0.load = 1'b0; if0.start = 1'b1;
        tick();
        if0.start = 1'b0; if0.enable = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({if0.out, if0.tc, if0.busy, if0.done} !== {8'd7, 3'b010}) begin
            miscompares++;
            $display("FAIL reset_pre_run: got %h want %h", {if0.out, if0.tc, if0.busy, if0.done}, {8'd7, 3'b010});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if0.enable = 1'b0;
        vectors++;
        if ({if0.out, if0.tc, if0.busy, if0.done} !== {8'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_mid_run: got %h want %h", {if0.out, if0.tc, if0.busy, if0.done}, {8'd0, 3'b000});
        end
        tick();
        vectors++;
        if (if0.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stays_idle: got busy=%b want 0", if0.busy);
        end
    endtask

    task automatic test_one_shot();
        logic [10:0] exp_v [8];
        exp_v = '{{8'd5, 3'b010}, {8'd4, 3'b010}, {8'd3, 3'b010}, {8'd2, 3'b010},
                  {8'd1, 3'b010}, {8'd0, 3'b101}, {8'd0, 3'b001}, {8'd0, 3'b001}};
        if0.data = 8'd5; if0.load = 1'b1;
        tick();
        if0.load = 1'b0;
        vectors++;
        if ({if0.out, if0.tc, if0.busy, if0.done} !== {8'd5, 3'b000}) begin
            miscompares++;
            $display("FAIL one_shot_load: got %h want %h", {if0.out, if0.tc, if0.busy, if0.done}, {8'd5, 3'b000});
        end
        if0.start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if0.start  = 1'b0;
            if0.enable = 1'b1;
            vectors++;
            if ({if0.out, if0.tc, if0.busy, if0.done} !== exp_v[i]) begin
                miscompares++;
                $display("FAIL one_shot_step%0d: got %h want %h", i, {if0.out, if0.tc, if0.busy, if0.done}, exp_v[i]);
            end
        end
        if0.ack = 1'b1;
        tick();
        if0.ack = 1'b0; if0.enable = 1'b0;
        vectors++;
        if ({if0.out, if0.tc, if0.busy, if0.done} !== {8'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL one_shot_ack: got %h want %h", {if0.out, if0.tc, if0.busy, if0.done}, {8'd0, 3'b000});
        end
    endtask

    task automatic test_enable_gating();
        logic [10:0] exp_v [6];
        logic        en_v  [6];
        exp_v = '{{8'd3, 3'b010}, {8'd3, 3'b010}, {8'd3, 3'b010},
                  {8'd2, 3'b010}, {8'd1, 3'b010}, {8'd0, 3'b101}};
        en_v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        if0.data = 8'd4; if0.load = 1'b1;
        tick();
        if0.load = 1'b0; if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if0.enable = en_v[i];
            tick();
            vectors++;
            if ({if0.out, if0.tc, if0.busy, if0.done} !== exp_v[i]) begin
                miscompares++;
                $display("FAIL gating_step%0d: got %h want %h", i, {if0.out, if0.tc, if0.busy, if0.done}, exp_v[i]);
            end
        end
        if0.enable = 1'b0; if0.ack = 1'b1;
        tick();
        if0.ack = 1'b0;
    endtask

    task automatic test_zero_load();
        if0.data = 8'd0; if0.load = 1'b1;
        tick();
        if0.load = 1'b0; if0.start = 1'b1;
        tick();
        if0.start = 1'b0; if0.enable = 1'b1;
        vectors++;
        if ({if0.out, if0.tc, if0.busy, if0.done} !== {8'd0, 3'b101}) begin
            miscompares++;
            $display("FAIL zero_load_tc: got %h want %h", {if0.out, if0.tc, if0.busy, if0.done}, {8'd0, 3'b101});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({if0.out, if0.tc, if0.busy, if0.done} !== {8'd0, 3'b001}) begin
                miscompares++;
                $display("FAIL zero_load_hold%0d: got %h want %h", i, {if0.out, if0.tc, if0.busy, if0.done}, {8'd0, 3'b001});
            end
        end
        // ack and start together in DONE: back to IDLE, start ignored.
        if0.ack = 1'b1; if0.start = 1'b1;
        tick();
        if0.ack = 1'b0; if0.start = 1'b0;
        tick();
        vectors++;
        if ({if0.out, if0.tc, if0.busy, if0.done} !== {8'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL done_ack_start: got %h want %h", {if0.out, if0.tc, if0.busy, if0.done}, {8'd0, 3'b000});
        end
        if0.enable = 1'b0;
    endtask

    task automatic test_priority();
        if0.data = 8'd9; if0.load = 1'b1; if0.start = 1'b1; if0.enable = 1'b1;
        tick();
        if0.load = 1'b0; if0.start = 1'b0;
        tick();
        vectors++;
        if ({if0.out, if0.tc, if0.busy, if0.done} !== {8'd9, 3'b000}) begin
            miscompares++;
            $display("FAIL load_beats_start: got %h want %h", {if0.out, if0.tc, if0.busy, if0.done}, {8'd9, 3'b000});
        end
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        tick();
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        vectors++;
        if ({if0.out, if0.tc, if0.busy, if0.done} !== {8'd7, 3'b010}) begin
            miscompares++;
            $display("FAIL start_in_run: got %h want %h", {if0.out, if0.tc, if0.busy, if0.done}, {8'd7, 3'b010});
        end
        if0.data = 8'd2; if0.load = 1'b1;
        tick();
        if0.load = 1'b0;
        tick();
        vectors++;
        if ({if0.out, if0.tc, if0.busy, if0.done} !== {8'd2, 3'b000}) begin
            miscompares++;
            $display("FAIL load_in_run: got %h want %h", {if0.out, if0.tc, if0.busy, if0.done}, {8'd2, 3'b000});
        end
        if0.enable = 1'b0;
    endtask

    task automatic test_auto_reload();
        logic [10:0] exp_v [9];
        exp_v = '{{8'd2, 3'b010}, {8'd1, 3'b010}, {8'd3, 3'b111},
                  {8'd2, 3'b011}, {8'd1, 3'b011}, {8'd3, 3'b111},
                  {8'd2, 3'b011}, {8'd1, 3'b011}, {8'd3, 3'b111}};
        if1.data = 8'd3; if1.load = 1'b1;
        tick();
        if1.load = 1'b0; if1.start = 1'b1;
        tick();
        if1.start = 1'b0; if1.enable = 1'b1;
        vectors++;
        if ({if1.out, if1.tc, if1.busy, if1.done} !== {8'd3, 3'b010}) begin
            miscompares++;
            $display("FAIL reload_start: got %h want %h", {if1.out, if1.tc, if1.busy, if1.done}, {8'd3, 3'b010});
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            vectors++;
            if ({if1.out, if1.tc, if1.busy, if1.done} !== exp_v[i]) begin
                miscompares++;
                $display("FAIL reload_step%0d: got %h want %h", i, {if1.out, if1.tc, if1.busy, if1.done}, exp_v[i]);
            end
        end
        if1.ack = 1'b1;
        tick();
        if1.ack = 1'b0;
        vectors++;
        if ({if1.out, if1.tc, if1.busy, if1.done} !== {8'd2, 3'b010}) begin
            miscompares++;
            $display("FAIL reload_ack_clear: got %h want %h", {if1.out, if1.tc, if1.busy, if1.done}, {8'd2, 3'b010});
        end
        tick();
        if1.ack = 1'b1;
        tick();
        if1.ack = 1'b0;
        vectors++;
        if ({if1.out, if1.tc, if1.busy, if1.done} !== {8'd3, 3'b111}) begin
            miscompares++;
            $display("FAIL reload_ack_vs_tc: got %h want %h", {if1.out, if1.tc, if1.busy, if1.done}, {8'd3, 3'b111});
        end
        if1.enable = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        clear_inputs();
        test_reset();
        test_one_shot();
        test_enable_gating();
        test_zero_load();
        test_priority();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        test_auto_reload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
